// File: rtl/divpoly_pkg.sv
// divpoly_pkg: shared constants and FSM state type for the post-division stages.
package divpoly_pkg;
    localparam int N_COEF = 677;
    localparam int AW = 11;
    localparam int CW = 13;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} liftState_t;
endpackage

// File: rtl/rem_centerlift_if.sv
// rem_centerlift_if: control, R-read, L-write and status bundle of rem_centerlift.
// Ports: start/modu/len (control in), mem_address_oR/mem_outputR (R read),
// mem_address_iL/mem_inputL/write_enableL (L write), degL/is_zero/busy/lift_done (status).
interface rem_centerlift_if;
    import divpoly_pkg::*;
    logic start;
    logic [11:0] modu;
    logic [AW-1:0] len;
    logic [AW-1:0] mem_address_oR;
    logic [CW-1:0] mem_outputR;
    logic [AW-1:0] mem_address_iL;
    logic [CW-1:0] mem_inputL;
    logic write_enableL;
    logic [AW-1:0] degL;
    logic is_zero;
    logic busy;
    logic lift_done;
    modport master (
        output start, modu, len, mem_outputR,
        input mem_address_oR, mem_address_iL, mem_inputL, write_enableL, degL, is_zero, busy, lift_done
    );
    modport slave (
        input start, modu, len, mem_outputR,
        output mem_address_oR, mem_address_iL, mem_inputL, write_enableL, degL, is_zero, busy, lift_done
    );
endinterface

// File: rtl/centerlift_core.sv
// centerlift_core: combinational centre-lift of one coefficient c modulo odd q into signed range.
// Ports: c (unsigned coefficient), q (modulus), out (signed lifted value).
// Macro RCL_REDUCE_EN: when defined, c >= q is first reduced by one subtraction of q.
module centerlift_core
    import divpoly_pkg::*;
(
    input  logic [CW-1:0]        c,
    input  logic [11:0]          q,
    output logic signed [CW-1:0] out
);
    logic [13:0] cWide, qWide, cRed, half, diff;
    always_comb begin
        cWide = {1'b0, c};
        qWide = {2'b0, q};
`ifdef RCL_REDUCE_EN
        cRed = cWide >= qWide ? cWide - qWide : cWide;
`else
        cRed = cWide;
`endif
        half = (qWide - 14'd1) >> 1;
        diff = cRed - qWide;
        out = $signed(cRed > half ? diff[CW-1:0] : cRed[CW-1:0]);
    end
endmodule

// File: rtl/rem_centerlift.sv
// rem_centerlift: streams R[0..len-1] through the centre-lift core into L, tracking degree and zero flag.
// Ports: clk, rst (async active-high), bus (rem_centerlift_if.slave: control, R read, L write, status).
// Macro RCL_REDUCE_EN: enables the single-subtraction pre-reduction inside centerlift_core.
module rem_centerlift #(
    parameter int N_COEF = 677,
    parameter int AW = 11,
    parameter int CW = 13
) (
    input logic clk,
    input logic rst,
    rem_centerlift_if.slave bus
);
    import divpoly_pkg::*;
    liftState_t state;
    logic [AW-1:0] lenQ, addr, addrD, lenSat;
    logic [11:0] modQ;
    logic rdValid;
    logic signed [CW-1:0] lifted;

    centerlift_core core (.c(bus.mem_outputR), .q(modQ), .out(lifted));

    assign bus.mem_address_oR = addr;
    assign lenSat = bus.len > AW'(N_COEF) ? AW'(N_COEF) : bus.len;

    // Pipeline: address in RUN, RAM data one cycle later (rdValid), registered write after that.
    // busy stays high through the lift_done cycle, which also blocks a start arriving with lift_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lenQ <= '0;
            addr <= '0;
            addrD <= '0;
            modQ <= '0;
            rdValid <= 1'b0;
            bus.mem_address_iL <= '0;
            bus.mem_inputL <= '0;
            bus.write_enableL <= 1'b0;
            bus.degL <= '0;
            bus.is_zero <= 1'b0;
            bus.busy <= 1'b0;
            bus.lift_done <= 1'b0;
        end else begin
            rdValid <= state == RUN;
            addrD <= addr;
            bus.write_enableL <= rdValid;
            if (rdValid) begin
                bus.mem_address_iL <= addrD;
                bus.mem_inputL <= lifted;
                if (lifted != '0) begin
                    bus.degL <= addrD;
                    bus.is_zero <= 1'b0;
                end
            end
            bus.lift_done <= state == DONE;
            if (bus.lift_done) bus.busy <= 1'b0;
            case (state)
                IDLE: if (bus.start && !bus.busy) begin
                    lenQ <= lenSat;
                    modQ <= bus.modu;
                    addr <= '0;
                    bus.degL <= '0;
                    bus.is_zero <= 1'b1;
                    bus.busy <= 1'b1;
                    state <= lenSat == '0 ? DONE : RUN;
                end
                RUN: if (addr == lenQ - 1'b1) state <= DRAIN; else addr <= addr + 1'b1;
                DRAIN: state <= DONE;
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule
